// File: rtl/cv32e40s_pkg.sv
// Shared definitions for the register-file ECC logic.
// Contents:
//   REGFILE_WORD_WIDTH  stored register-file word width (32 data + 6 check bits)
//   rf_addr_t           register-file word address
//   RF_ECC_MASK         data-bit coverage mask of each of the 6 check bits
//   RF_ECC_INV          check bits that are stored inverted (1, 3 and 5)
//   scrub_state_e       background scrubber FSM states
package cv32e40s_pkg;

  localparam int REGFILE_WORD_WIDTH = 38;
  localparam int RF_ADDR_WIDTH      = 5;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  // Entry k is the set of data bits folded into check bit k.
  localparam logic [5:0][31:0] RF_ECC_MASK = {
    32'hFC000000,  // k = 5
    32'h03FFF800,  // k = 4
    32'h03FC07F0,  // k = 3
    32'hE3C3C78E,  // k = 2
    32'h9B33366D,  // k = 1
    32'h56AAAD5B   // k = 0
  };

  // An all-zero stored word is therefore not a valid codeword, which catches
  // stuck-at-zero storage.
  localparam logic [5:0] RF_ECC_INV = 6'b101010;

  typedef enum logic [1:0] {
    SCRUB_IDLE = 2'd0,
    SCRUB_WAIT = 2'd1,
    SCRUB_REQ  = 2'd2
  } scrub_state_e;

endpackage

// File: rtl/cv32e40s_rf_ecc_syndrome.sv
// Combinational Hamming syndrome of one stored register-file word.
// Ports:
//   word      in   stored word, data in [31:0], check bits in [37:32]
//   syndrome  out  6-bit syndrome; zero means the word is a valid codeword
module cv32e40s_rf_ecc_syndrome
  import cv32e40s_pkg::*;
(
  input  logic [REGFILE_WORD_WIDTH-1:0] word,
  output logic [5:0]                    syndrome
);

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < 6; k++) begin
      syndrome[k] = (^(word[31:0] & RF_ECC_MASK[k])) ^ word[32+k] ^ RF_ECC_INV[k];
    end
  end

endmodule

// File: rtl/cv32e40s_rf_ecc_scrubber.sv
// Background scrubber: borrows an idle register-file read port, walks every
// word, recomputes the ECC syndrome and reports latent errors.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable_i          scrubbing enabled; dropping it returns to IDLE next cycle
//   interval_i        idle cycles between reads, sampled at every reload
//   req_o / raddr_o   read-port request and scrub address, stable until gnt_i
//   gnt_i / rdata_i   grant and same-cycle read data
//   clear_i           clears the sticky error flag only
//   alert_major_o     one-cycle pulse per erroneous word
//   err_sticky_o      error seen since last clear
//   err_addr_o        address of the first error since last clear
//   err_syndrome_o    syndrome of that first error
//   sweep_done_o      one-cycle pulse after the last address was scrubbed
//   state_o           FSM state, for observation
// Handshake: a read transfers in a cycle where req_o=1 and gnt_i=1; once
// raised, req_o and raddr_o hold until that cycle (or until enable_i drops);
// gnt_i is ignored while req_o=0.
module cv32e40s_rf_ecc_scrubber
  import cv32e40s_pkg::*;
#(
  parameter int NUM_WORDS      = 32,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic [INTERVAL_WIDTH-1:0]     interval_i,
  output logic                          req_o,
  output rf_addr_t                      raddr_o,
  input  logic                          gnt_i,
  input  logic [REGFILE_WORD_WIDTH-1:0] rdata_i,
  input  logic                          clear_i,
  output logic                          alert_major_o,
  output logic                          err_sticky_o,
  output rf_addr_t                      err_addr_o,
  output logic [5:0]                    err_syndrome_o,
  output logic                          sweep_done_o,
  output logic [1:0]                    state_o
);

  localparam logic [1:0] S_IDLE = SCRUB_IDLE;
  localparam logic [1:0] S_WAIT = SCRUB_WAIT;
  localparam logic [1:0] S_REQ  = SCRUB_REQ;

  logic [1:0]                state;
  logic [INTERVAL_WIDTH-1:0] cnt;
  rf_addr_t                  addr;
  logic [5:0]                syndrome;
  logic                      granted;
  logic                      word_err;
  logic                      last_word;

  cv32e40s_rf_ecc_syndrome u_syndrome (
    .word     (rdata_i),
    .syndrome (syndrome)
  );

  assign req_o     = (state == S_REQ);
  assign raddr_o   = addr;
  assign state_o   = state;
  assign granted   = req_o & gnt_i;
  assign word_err  = |syndrome;
  assign last_word = (addr == rf_addr_t'(NUM_WORDS - 1));

  // Sequencing. A grant in the same cycle that enable_i drops still counts
  // as a completed read, so the address advances and the result is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            state <= S_WAIT;
            cnt   <= interval_i;
          end
        end
        S_WAIT: begin
          if (!enable_i) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_REQ;
          end else begin
            cnt <= cnt - INTERVAL_WIDTH'(1);
          end
        end
        S_REQ: begin
          if (gnt_i) begin
            addr <= last_word ? '0 : addr + rf_addr_t'(1);
          end
          if (!enable_i) begin
            state <= S_IDLE;
          end else if (gnt_i) begin
            state <= S_WAIT;
            cnt   <= interval_i;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Error capture, visible the cycle after the granted read. A new error
  // beats a simultaneous clear and then reloads address/syndrome, since the
  // clear has just declared the previous capture consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      alert_major_o  <= 1'b0;
      sweep_done_o   <= 1'b0;
      err_sticky_o   <= 1'b0;
      err_addr_o     <= '0;
      err_syndrome_o <= '0;
    end else begin
      alert_major_o <= granted & word_err;
      sweep_done_o  <= granted & last_word;
      if (granted && word_err) begin
        err_sticky_o <= 1'b1;
        if (!err_sticky_o || clear_i) begin
          err_addr_o     <= addr;
          err_syndrome_o <= syndrome;
        end
      end else if (clear_i) begin
        err_sticky_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cv32e40s_rf_ecc_scrubber.md
# cv32e40s_rf_ecc_scrubber

Background scrubber for the ECC-protected register file. It borrows an idle register-file read port, walks every word, and recomputes the 6-bit Hamming syndrome over each stored 38-bit word (32 data + 6 ECC). A non-zero syndrome raises a major alert and latches the faulting address. This catches latent upsets in registers the pipeline does not read for long periods. It sits beside the register file's read-side ECC check and consumes the same stored-word format.

## Interface
Parameters:
- NUM_WORDS, 32: register-file words scrubbed; addresses 0..NUM_WORDS-1.
- INTERVAL_WIDTH, 16: width of the inter-read interval counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- enable_i  in  1  scrubbing enabled
- interval_i  in  INTERVAL_WIDTH  idle cycles between scrub reads; sampled at each reload
- req_o  out  1  read-port request
- raddr_o  out  rf_addr_t  address of the word being scrubbed
- gnt_i  in  1  read port granted; rdata_i is valid in the same cycle
- rdata_i  in  REGFILE_WORD_WIDTH (38)  stored word, ECC in [37:32]
- clear_i  in  1  clears the sticky error
- alert_major_o  out  1  one-cycle pulse per detected error
- err_sticky_o  out  1  at least one error seen since the last clear
- err_addr_o  out  rf_addr_t  address of the first error since the last clear
- err_syndrome_o  out  6  syndrome of that first error
- sweep_done_o  out  1  one-cycle pulse after address NUM_WORDS-1 has been scrubbed

## Operation
- FSM states: IDLE, WAIT, REQ. Reset state is IDLE.
- IDLE: all outputs idle. If enable_i=1, go to WAIT and load cnt=interval_i.
- WAIT: if cnt==0, go to REQ; otherwise decrement cnt.
- REQ: req_o=1 and raddr_o=addr, both held stable until gnt_i.
  - On gnt_i: evaluate the syndrome of rdata_i and advance addr. addr wraps from NUM_WORDS-1 to 0.
  - Then go to WAIT and reload cnt=interval_i.
- Syndrome: syn[k] = ^(rdata_i[31:0] & M[k]) ^ rdata_i[32+k] ^ INV[k].
  - M = {0x56AAAD5B, 0x9B33366D, 0xE3C3C78E, 0x03FC07F0, 0x03FFF800, 0xFC000000} for k=0..5.
  - INV = 6'b101010: check bits 1, 3 and 5 are stored inverted.
  - Error means syn != 0. No correction is attempted; single- and double-bit errors are reported the same way.
- Error capture, one cycle after the granted read:
  - alert_major_o pulses and err_sticky_o sets.
  - err_addr_o/err_syndrome_o are loaded only if err_sticky_o was 0. The first error is preserved.
- clear_i clears err_sticky_o only. err_addr_o/err_syndrome_o keep their values.
  - If clear_i coincides with an error capture, the error wins: sticky stays 1, and address/syndrome reload with the new error.
- enable_i=0 in any state: go to IDLE next cycle and drop req_o in that cycle without waiting for gnt_i.
  - addr is retained, so a later enable resumes where scrubbing stopped.
  - gnt_i is ignored whenever req_o=0.
- An error still in flight (gnt already received) completes its capture even if enable_i drops.
- rst mid-operation: everything returns to its reset value next cycle; addr returns to 0.
- A concurrent write to raddr_o in the grant cycle is harmless: the write port stores atomically encoded words, so both old and new values are consistent.

## Timing
- Reset values: req_o=0, raddr_o=0, alert_major_o=0, err_sticky_o=0, err_addr_o=0, err_syndrome_o=0, sweep_done_o=0.
- raddr_o is driven from the registered addr and is valid whenever req_o=1.
- Detection latency: alert, sticky and capture are all visible exactly 1 cycle after the gnt_i cycle.
- sweep_done_o pulses 1 cycle after the gnt_i cycle for address NUM_WORDS-1. It can coincide with alert_major_o.
- Read cadence with an immediate grant: one read per interval_i+2 cycles.
  - interval_i=0 gives REQ, WAIT, REQ..., one read every 2 cycles.
- Starting from IDLE, the first req_o asserts interval_i+2 cycles after enable_i rises.

## Structure
- Shared package (cv32e40s_pkg):
  - ECC mask constants M[0..5].
  - The inversion constant 6'b101010.
  - REGFILE_WORD_WIDTH.
  - A scrubber state enum.
- Sub-module cv32e40s_rf_ecc_syndrome: combinational 38-bit word in, 6-bit syndrome out. It is instantiable by any other ECC checker so the code definition lives in one place.

## Test plan
- Clean sweep: all words 0x2A_0000_0000, interval_i=0, gnt_i tied 1.
  - raddr_o reads 0..31.
  - sweep_done_o pulses once per 64 cycles.
  - alert_major_o stays 0.
- Single-bit error: word 5 = 0x2A_0000_0001.
  - alert pulses 1 cycle after addr 5 is granted.
  - err_addr_o=5, err_syndrome_o=0x03.
- Double-bit error and ECC-bit error:
  - Word 9 = 0x2A_0000_0003 gives syndrome 0x06.
  - Word 12 = 0x0A_0000_0000 gives syndrome 0x20.
  - With no clear in between, the capture keeps addr 9 / 0x06 while alert pulses twice.
- Handshake:
  - gnt_i withheld 10 cycles: req_o and raddr_o stay stable.
  - enable_i dropped mid-REQ: req_o=0 next cycle.
  - On re-enable, scrubbing resumes at the same address.
- Clear race: clear_i asserted in the same cycle as a new error capture → err_sticky_o remains 1 and the new address is captured.
- Reset mid-sweep (at addr 17, WAIT with cnt=100): next cycle everything is back to reset values, and the first request after enable targets addr 0.
